// File: rtl/wb_write_queue.sv
// Write-back queue: merges load and ALU results into one registered register-file write port,
// tracks registers with uncommitted writes and flags decode hazards.
module wb_write_queue #(
    parameter int unsigned DEPTH = 4
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         mem_valid,
    input  logic [3:0]                   mem_dest,
    input  logic [31:0]                  mem_result,
    output logic                         mem_ready,
    input  logic                         alu_valid,
    input  logic [3:0]                   alu_dest,
    input  logic [31:0]                  alu_result,
    output logic                         alu_ready,
    output logic                         writeBackEn,
    output logic [3:0]                   Dest_wb,
    output logic [31:0]                  Result_WB,
    input  logic [3:0]                   src1,
    input  logic [3:0]                   src2,
    output logic                         hazard,
    output logic [14:0]                  pending,
    output logic [$clog2(DEPTH+1)-1:0]   count
);

    localparam int unsigned PW = $clog2(DEPTH);
    localparam int unsigned CW = $clog2(DEPTH + 1);

    logic [PW-1:0] r_wr_ptr;
    logic [PW-1:0] r_rd_ptr;
    logic [CW-1:0] r_count;
    logic [3:0]    r_dest [DEPTH];
    logic [31:0]   r_data [DEPTH];
    logic          r_wben;
    logic [3:0]    r_dest_wb;
    logic [31:0]   r_result_wb;

    logic          w_mem_push;
    logic          w_alu_push;
    logic          w_pop;
    logic [PW-1:0] w_alu_slot;
    logic [15:0]   w_pend;

    // Readys look only at occupancy, so a same-cycle pop never widens acceptance.
    always_comb begin
        mem_ready = rst & (r_count < CW'(DEPTH));
        if (mem_valid) begin
            alu_ready = rst & (r_count < CW'(DEPTH - 1));
        end else begin
            alu_ready = rst & (r_count < CW'(DEPTH));
        end
    end

    // Writes to r15 complete the handshake but are dropped.
    assign w_mem_push = mem_valid & mem_ready & (mem_dest != 4'hF);
    assign w_alu_push = alu_valid & alu_ready & (alu_dest != 4'hF);
    assign w_pop      = (r_count != '0);
    assign w_alu_slot = r_wr_ptr + PW'(w_mem_push);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_wr_ptr    <= '0;
            r_rd_ptr    <= '0;
            r_count     <= '0;
            r_wben      <= 1'b0;
            r_dest_wb   <= '0;
            r_result_wb <= '0;
        end else begin
            r_wr_ptr <= r_wr_ptr + PW'(w_mem_push) + PW'(w_alu_push);
            r_count  <= r_count + CW'(w_mem_push) + CW'(w_alu_push) - CW'(w_pop);
            r_wben   <= w_pop;
            if (w_pop) begin
                r_rd_ptr    <= r_rd_ptr + PW'(1);
                r_dest_wb   <= r_dest[r_rd_ptr];
                r_result_wb <= r_data[r_rd_ptr];
            end
        end
    end

    // Payload storage needs no reset; occupancy alone decides which slots are live.
    always_ff @(posedge clk) begin
        if (w_mem_push) begin
            r_dest[r_wr_ptr] <= mem_dest;
            r_data[r_wr_ptr] <= mem_result;
        end
        if (w_alu_push) begin
            r_dest[w_alu_slot] <= alu_dest;
            r_data[w_alu_slot] <= alu_result;
        end
    end

    always_comb begin
        w_pend = '0;
        for (int unsigned k = 0; k < DEPTH; k++) begin
            if (CW'(PW'(PW'(k) - r_rd_ptr)) < r_count) begin
                w_pend[r_dest[k]] = 1'b1;
            end
        end
        if (r_wben) begin
            w_pend[r_dest_wb] = 1'b1;
        end
    end

    assign hazard      = ((src1 != 4'hF) & w_pend[src1]) | ((src2 != 4'hF) & w_pend[src2]);
    assign pending     = w_pend[14:0];
    assign count       = r_count;
    assign writeBackEn = r_wben;
    assign Dest_wb     = r_dest_wb;
    assign Result_WB   = r_result_wb;

endmodule

// File: tb/tb_wb_write_queue.sv
// Self-checking bench for wb_write_queue: directed scenarios plus randomized traffic compared
// against a queue-based reference model.
module tb_wb_write_queue;

    localparam int unsigned DEPTH = 4;

    logic        clk;
    logic        rst;
    logic        mem_valid;
    logic [3:0]  mem_dest;
    logic [31:0] mem_result;
    logic        mem_ready;
    logic        alu_valid;
    logic [3:0]  alu_dest;
    logic [31:0] alu_result;
    logic        alu_ready;
    logic        writeBackEn;
    logic [3:0]  Dest_wb;
    logic [31:0] Result_WB;
    logic [3:0]  src1;
    logic [3:0]  src2;
    logic        hazard;
    logic [14:0] pending;
    logic [2:0]  count;

    int checks = 0;
    int errors = 0;

    wb_write_queue #(.DEPTH(DEPTH)) dut (
        .clk        (clk),
        .rst        (rst),
        .mem_valid  (mem_valid),
        .mem_dest   (mem_dest),
        .mem_result (mem_result),
        .mem_ready  (mem_ready),
        .alu_valid  (alu_valid),
        .alu_dest   (alu_dest),
        .alu_result (alu_result),
        .alu_ready  (alu_ready),
        .writeBackEn(writeBackEn),
        .Dest_wb    (Dest_wb),
        .Result_WB  (Result_WB),
        .src1       (src1),
        .src2       (src2),
        .hazard     (hazard),
        .pending    (pending),
        .count      (count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference model: an ordered list of accepted writes plus the last issued write.
    int unsigned mq_dest[$];
    logic [31:0] mq_data[$];
    logic        m_en;
    logic [3:0]  m_dest;
    logic [31:0] m_data;
    int          m_sz;
    bit          m_mr;
    bit          m_ar;

    always @(posedge clk or negedge rst) begin
        if (!rst) begin
            mq_dest.delete();
            mq_data.delete();
            m_en   = 1'b0;
            m_dest = '0;
            m_data = '0;
        end else begin
            m_sz = mq_dest.size();
            m_mr = (m_sz < DEPTH);
            m_ar = mem_valid ? (m_sz < DEPTH - 1) : (m_sz < DEPTH);
            if (m_sz > 0) begin
                m_en   = 1'b1;
                m_dest = 4'(mq_dest.pop_front());
                m_data = mq_data.pop_front();
            end else begin
                m_en = 1'b0;
            end
            if (mem_valid && m_mr && mem_dest != 4'hF) begin
                mq_dest.push_back(mem_dest);
                mq_data.push_back(mem_result);
            end
            if (alu_valid && m_ar && alu_dest != 4'hF) begin
                mq_dest.push_back(alu_dest);
                mq_data.push_back(alu_result);
            end
        end
    end

    function automatic logic [14:0] exp_pending();
        logic [15:0] p;
        p = '0;
        foreach (mq_dest[i]) p[mq_dest[i]] = 1'b1;
        if (m_en) p[m_dest] = 1'b1;
        return p[14:0];
    endfunction

    function automatic logic exp_hazard();
        logic [14:0] p;
        p = exp_pending();
        return ((src1 != 4'hF) && p[src1]) || ((src2 != 4'hF) && p[src2]);
    endfunction

    task automatic idle_inputs();
        mem_valid  = 1'b0;
        alu_valid  = 1'b0;
        mem_dest   = '0;
        alu_dest   = '0;
        mem_result = '0;
        alu_result = '0;
    endtask

    task automatic test_reset();
        rst  = 1'b0;
        src1 = 4'hF;
        src2 = 4'hF;
        idle_inputs();
        repeat (2) @(negedge clk);
        #1;
        checks++;
        if ({writeBackEn, Dest_wb, Result_WB} !== 37'd0) begin
            errors++;
            $display("FAIL reset_wport: got %0h required 0", {writeBackEn, Dest_wb, Result_WB});
        end
        checks++;
        if ({count, pending, hazard, mem_ready, alu_ready} !== 21'd0) begin
            errors++;
            $display("FAIL reset_status: got %0h required 0",
                     {count, pending, hazard, mem_ready, alu_ready});
        end
        @(negedge clk);
        rst = 1'b1;
        #1;
        checks++;
        if ({mem_ready, alu_ready, count} !== {2'b11, 3'd0}) begin
            errors++;
            $display("FAIL reset_release_ready: got %b required 11000",
                     {mem_ready, alu_ready, count});
        end
    endtask

    task automatic test_single_push();
        @(negedge clk);
        alu_valid  = 1'b1;
        alu_dest   = 4'd3;
        alu_result = 32'h1234_5678;
        @(negedge clk);
        idle_inputs();
        #1;
        checks++;
        if (count !== 3'd1 || writeBackEn !== 1'b0) begin
            errors++;
            $display("FAIL single_after_accept: got count %0d en %b required 1 0",
                     count, writeBackEn);
        end
        @(negedge clk);
        #1;
        checks++;
        if ({writeBackEn, Dest_wb, Result_WB} !== {1'b1, 4'd3, 32'h1234_5678}) begin
            errors++;
            $display("FAIL single_write: got en %b dest %0d data %h required 1 3 12345678",
                     writeBackEn, Dest_wb, Result_WB);
        end
        @(negedge clk);
        #1;
        checks++;
        if (writeBackEn !== 1'b0 || count !== 3'd0) begin
            errors++;
            $display("FAIL single_idle: got en %b count %0d required 0 0", writeBackEn, count);
        end
    endtask

    task automatic test_ordering();
        @(negedge clk);
        mem_valid  = 1'b1;
        mem_dest   = 4'd1;
        mem_result = 32'hAAAA_0000;
        alu_valid  = 1'b1;
        alu_dest   = 4'd2;
        alu_result = 32'hBBBB_0000;
        @(negedge clk);
        idle_inputs();
        #1;
        checks++;
        if (count !== 3'd2 || pending !== 15'b000_0000_0000_0110) begin
            errors++;
            $display("FAIL order_both_queued: got count %0d pending %b required 2 110",
                     count, pending);
        end
        @(negedge clk);
        #1;
        checks++;
        if ({writeBackEn, Dest_wb, Result_WB} !== {1'b1, 4'd1, 32'hAAAA_0000}) begin
            errors++;
            $display("FAIL order_first: got en %b dest %0d data %h required 1 1 aaaa0000",
                     writeBackEn, Dest_wb, Result_WB);
        end
        @(negedge clk);
        #1;
        checks++;
        if ({writeBackEn, Dest_wb, Result_WB} !== {1'b1, 4'd2, 32'hBBBB_0000}) begin
            errors++;
            $display("FAIL order_second: got en %b dest %0d data %h required 1 2 bbbb0000",
                     writeBackEn, Dest_wb, Result_WB);
        end
        @(negedge clk);
        #1;
        checks++;
        if (writeBackEn !== 1'b0) begin
            errors++;
            $display("FAIL order_done: got en %b required 0", writeBackEn);
        end
    endtask

    task automatic test_backpressure();
        int unsigned exp_cnt;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            mem_valid  = 1'b1;
            mem_dest   = 4'((2 * i) % 15);
            mem_result = 32'hC0DE_0000 | 32'(i);
            alu_valid  = 1'b1;
            alu_dest   = 4'((2 * i + 1) % 15);
            alu_result = 32'hF00D_0000 | 32'(i);
            #1;
            exp_cnt = (i == 0) ? 0 : (i == 1) ? 2 : 3;
            checks++;
            if (count !== 3'(exp_cnt)) begin
                errors++;
                $display("FAIL bp_count[%0d]: got %0d required %0d", i, count, exp_cnt);
            end
            checks++;
            if (mem_ready !== 1'b1 || alu_ready !== (exp_cnt < 3)) begin
                errors++;
                $display("FAIL bp_ready[%0d]: got mem %b alu %b required 1 %b",
                         i, mem_ready, alu_ready, exp_cnt < 3);
            end
            checks++;
            if (writeBackEn !== m_en || (m_en && {Dest_wb, Result_WB} !== {m_dest, m_data})) begin
                errors++;
                $display("FAIL bp_write[%0d]: got %b %0d %h required %b %0d %h",
                         i, writeBackEn, Dest_wb, Result_WB, m_en, m_dest, m_data);
            end
        end
        idle_inputs();
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            #1;
            checks++;
            if (writeBackEn !== m_en || (m_en && {Dest_wb, Result_WB} !== {m_dest, m_data})) begin
                errors++;
                $display("FAIL bp_drain[%0d]: got %b %0d %h required %b %0d %h",
                         i, writeBackEn, Dest_wb, Result_WB, m_en, m_dest, m_data);
            end
        end
    endtask

    task automatic test_discard();
        @(negedge clk);
        alu_valid  = 1'b1;
        alu_dest   = 4'hF;
        alu_result = 32'hDEAD_BEEF;
        #1;
        checks++;
        if (alu_ready !== 1'b1) begin
            errors++;
            $display("FAIL discard_ready: got %b required 1", alu_ready);
        end
        @(negedge clk);
        idle_inputs();
        #1;
        checks++;
        if (count !== 3'd0 || pending !== 15'd0) begin
            errors++;
            $display("FAIL discard_queue: got count %0d pending %h required 0 0", count, pending);
        end
        @(negedge clk);
        #1;
        checks++;
        if (writeBackEn !== 1'b0) begin
            errors++;
            $display("FAIL discard_write: got en %b required 0", writeBackEn);
        end
    endtask

    task automatic test_hazard();
        @(negedge clk);
        src1       = 4'd5;
        src2       = 4'hF;
        alu_valid  = 1'b1;
        alu_dest   = 4'd5;
        alu_result = 32'h0000_0055;
        #1;
        checks++;
        if (hazard !== 1'b0) begin
            errors++;
            $display("FAIL hazard_before: got %b required 0", hazard);
        end
        @(negedge clk);
        idle_inputs();
        #1;
        checks++;
        if (hazard !== 1'b1 || pending !== 15'b000_0000_0010_0000) begin
            errors++;
            $display("FAIL hazard_queued: got %b pending %b required 1 100000", hazard, pending);
        end
        @(negedge clk);
        #1;
        checks++;
        if (hazard !== 1'b1 || writeBackEn !== 1'b1) begin
            errors++;
            $display("FAIL hazard_writing: got hazard %b en %b required 1 1", hazard, writeBackEn);
        end
        @(negedge clk);
        #1;
        checks++;
        if (hazard !== 1'b0 || pending !== 15'd0) begin
            errors++;
            $display("FAIL hazard_cleared: got %b pending %h required 0 0", hazard, pending);
        end
        src1 = 4'hF;
    endtask

    task automatic test_random();
        for (int i = 0; i < 400; i++) begin
            @(negedge clk);
            mem_valid  = ($urandom_range(0, 9) < 6);
            mem_dest   = 4'($urandom_range(0, 15));
            mem_result = $urandom;
            alu_valid  = ($urandom_range(0, 9) < 6);
            alu_dest   = 4'($urandom_range(0, 15));
            alu_result = $urandom;
            src1       = 4'($urandom_range(0, 15));
            src2       = 4'($urandom_range(0, 15));
            #1;
            checks++;
            if (count !== 3'(mq_dest.size())) begin
                errors++;
                $display("FAIL rnd_count[%0d]: got %0d required %0d", i, count, mq_dest.size());
            end
            checks++;
            if (mem_ready !== (mq_dest.size() < DEPTH) ||
                alu_ready !== (mem_valid ? (mq_dest.size() < DEPTH - 1)
                                         : (mq_dest.size() < DEPTH))) begin
                errors++;
                $display("FAIL rnd_ready[%0d]: got mem %b alu %b with count %0d mem_valid %b",
                         i, mem_ready, alu_ready, mq_dest.size(), mem_valid);
            end
            checks++;
            if (writeBackEn !== m_en || (m_en && {Dest_wb, Result_WB} !== {m_dest, m_data})) begin
                errors++;
                $display("FAIL rnd_write[%0d]: got %b %0d %h required %b %0d %h",
                         i, writeBackEn, Dest_wb, Result_WB, m_en, m_dest, m_data);
            end
            checks++;
            if (pending !== exp_pending() || hazard !== exp_hazard()) begin
                errors++;
                $display("FAIL rnd_pending[%0d]: got %h %b required %h %b",
                         i, pending, hazard, exp_pending(), exp_hazard());
            end
        end
        idle_inputs();
        src1 = 4'hF;
        src2 = 4'hF;
    endtask

    task automatic test_mid_reset();
        repeat (6) @(negedge clk);
        for (int i = 0; i < 2; i++) begin
            mem_valid  = 1'b1;
            mem_dest   = 4'd7;
            mem_result = 32'h7777_0000 | 32'(i);
            alu_valid  = 1'b1;
            alu_dest   = 4'd8;
            alu_result = 32'h8888_0000 | 32'(i);
            @(negedge clk);
        end
        idle_inputs();
        src1 = 4'd8;
        #1;
        checks++;
        if (count !== 3'd3 || hazard !== 1'b1) begin
            errors++;
            $display("FAIL midrst_setup: got count %0d hazard %b required 3 1", count, hazard);
        end
        #2;
        rst = 1'b0;
        #1;
        checks++;
        if ({count, writeBackEn, pending, hazard, mem_ready, alu_ready} !== 22'd0) begin
            errors++;
            $display("FAIL midrst_immediate: got %h required 0",
                     {count, writeBackEn, pending, hazard, mem_ready, alu_ready});
        end
        checks++;
        if ({Dest_wb, Result_WB} !== 36'd0) begin
            errors++;
            $display("FAIL midrst_wport: got %h required 0", {Dest_wb, Result_WB});
        end
        @(negedge clk);
        rst = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            #1;
            checks++;
            if (writeBackEn !== 1'b0 || count !== 3'd0) begin
                errors++;
                $display("FAIL midrst_after[%0d]: got en %b count %0d required 0 0",
                         i, writeBackEn, count);
            end
        end
        src1 = 4'hF;
    endtask

    initial begin
        test_reset();
        test_single_push();
        test_ordering();
        test_backpressure();
        test_discard();
        test_hazard();
        test_random();
        test_mid_reset();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not complete in time");
        $fatal(1, "timeout");
    end

endmodule
